// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the multiply-accumulate stage.
//   state_t      - control state encoding (IDLE / RUN / DONE)
//   acc_width()  - accumulator width from operand width and guard bits
//   cnt_width()  - width of a counter that must hold the value 0..len
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int acc_width(input int n, input int g);
        return 2 * n + g;
    endfunction

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/mult_n.sv
// mult_n: combinational unsigned N x N array multiplier.
// Ports:
//   a  in  N    multiplicand
//   b  in  N    multiplier
//   p  out 2N   full-width product (never truncated)
module mult_n #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    // One shifted partial-product row per multiplier bit, summed as a chain.
    logic [2*N-1:0] pp   [N];
    logic [2*N-1:0] psum [N+1];

    assign psum[0] = '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            assign pp[gi]       = b[gi] ? ({{N{1'b0}}, a} << gi) : '0;
            assign psum[gi + 1] = psum[gi] + pp[gi];
        end
    endgenerate

    assign p = psum[N];

endmodule

// File: rtl/mac_accum.sv
// mac_accum: pipelined multiply-accumulate stage.
// Registers operand pairs (S1), registers their 2N-bit product (S2) and adds
// LEN products into a saturating accumulator (S3). The block sum is offered
// on a valid/ready output and held until the consumer takes it.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin a block (only honoured in IDLE)
//   abort      in   1      discard the current block, return to IDLE
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      stage accepts operands
//   a, b       in   N      unsigned operands
//   out_valid  out  1      acc_out/ovf valid, held until out_ready
//   out_ready  in   1      consumer accepts result
//   acc_out    out  ACC_W  block sum (saturated)
//   ovf        out  1      sticky: block saturated
module mac_accum
    import mac_pkg::*;
#(
    parameter int N   = 4,
    parameter int G   = 4,
    parameter int LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N+G-1:0] acc_out,
    output logic             ovf
);

    localparam int ACC_W = acc_width(N, G);
    localparam int CNT_W = cnt_width(LEN);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] accepted_reg, summed_reg;
    logic [N-1:0]     a_reg, b_reg;
    logic             v1_reg, v2_reg;
    logic [2*N-1:0]   prod, prod_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_reg;

    logic             accept;
    logic             begin_blk;
    logic             last_add;
    logic [ACC_W:0]   sum_ext;
    logic             sat;

    mult_n #(.N(N)) u_mult (
        .a (a_reg),
        .b (b_reg),
        .p (prod)
    );

    assign in_ready  = (state_reg == ST_RUN) && (accepted_reg < LEN_C);
    assign accept    = in_valid && in_ready;
    assign begin_blk = (state_reg == ST_IDLE) && start && !abort;
    // The final add and the move to DONE happen on the same edge.
    assign last_add  = (state_reg == ST_RUN) && v2_reg && (summed_reg == LAST_C);

    // One extra bit catches the carry that signals saturation.
    assign sum_ext = {1'b0, acc_reg} + (ACC_W + 1)'(prod_reg);
    assign sat     = sum_ext[ACC_W];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start && !abort) state_next = ST_RUN;
            ST_RUN: begin
                if (abort)         state_next = ST_IDLE;
                else if (last_add) state_next = ST_DONE;
            end
            ST_DONE: if (abort || out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            accepted_reg <= '0;
            summed_reg   <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            v1_reg       <= 1'b0;
            v2_reg       <= 1'b0;
            prod_reg     <= '0;
            acc_reg      <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            prod_reg  <= prod;
            if (abort) begin
                // Abort wins over everything: flush the pipeline and the sum.
                v1_reg       <= 1'b0;
                v2_reg       <= 1'b0;
                acc_reg      <= '0;
                ovf_reg      <= 1'b0;
                accepted_reg <= '0;
                summed_reg   <= '0;
            end else if (begin_blk) begin
                v1_reg       <= 1'b0;
                v2_reg       <= 1'b0;
                acc_reg      <= '0;
                ovf_reg      <= 1'b0;
                accepted_reg <= '0;
                summed_reg   <= '0;
            end else begin
                v1_reg <= accept;
                v2_reg <= v1_reg;
                if (accept) begin
                    a_reg        <= a;
                    b_reg        <= b;
                    accepted_reg <= accepted_reg + 1'b1;
                end
                if (v2_reg) begin
                    acc_reg    <= sat ? '1 : sum_ext[ACC_W-1:0];
                    ovf_reg    <= ovf_reg | sat;
                    summed_reg <= summed_reg + 1'b1;
                end
            end
        end
    end

    assign out_valid = (state_reg == ST_DONE);
    assign acc_out   = acc_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_mac_accum.sv
module tb_mac_accum;

    localparam int N    = 4;
    localparam int G    = 4;
    localparam int LEN  = 4;
    localparam int AW   = 2 * N + G;
    localparam int SG   = 0;
    localparam int SLEN = 2;
    localparam int SAW  = 2 * N + SG;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Main instance (N=4, G=4, LEN=4)
    logic          start = 0, abort = 0, in_valid = 0, out_ready = 0;
    logic          in_ready, out_valid, ovf;
    logic [N-1:0]  a = '0, b = '0;
    logic [AW-1:0] acc_out;

    // Saturation instance (N=4, G=0, LEN=2)
    logic           s_start = 0, s_abort = 0, s_in_valid = 0, s_out_ready = 0;
    logic           s_in_ready, s_out_valid, s_ovf;
    logic [N-1:0]   s_a = '0, s_b = '0;
    logic [SAW-1:0] s_acc_out;

    int tests = 0;
    int fails = 0;
    int op_a [LEN];
    int op_b [LEN];

    always #5 clk = ~clk;

    mac_accum #(.N(N), .G(G), .LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .ovf(ovf)
    );

    mac_accum #(.N(N), .G(SG), .LEN(SLEN)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .acc_out(s_acc_out), .ovf(s_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present n operand pairs back-to-back, counting only real handshakes.
    task automatic feed(input string tag, input int n, input int va, input int vb);
        int idx = 0;
        int budget = 0;
        bit took;
        while (idx < n && budget < 50) begin
            in_valid = 1'b1;
            a = N'(va);
            b = N'(vb);
            took = in_ready;
            tick();
            if (took) idx++;
            budget++;
        end
        in_valid = 1'b0;
        chk({tag, "_feed_count"}, 64'(idx), 64'(n));
    endtask

    // mode 0: back-to-back, 1: random bubbles, 2: in_valid from vpat bits
    task automatic run_main(input string tag, input int mode, input logic [7:0] vpat,
                            input int hold, input bit check_lat);
        longint s = 0;
        longint exp_acc;
        logic   exp_ovf;
        int     idx = 0;
        int     cyc = 0;
        bit     took;
        for (int i = 0; i < LEN; i++) s += longint'(op_a[i]) * longint'(op_b[i]);
        exp_ovf = (s >= (64'd1 << AW));
        exp_acc = exp_ovf ? ((64'd1 << AW) - 1) : s;

        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_in_ready_run"}, 64'(in_ready), 64'd1);

        while (idx < LEN && cyc < 200) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = 1'($urandom_range(0, 1));
                default: in_valid = (cyc < 8) ? vpat[cyc[2:0]] : 1'b0;
            endcase
            a = N'(op_a[idx]);
            b = N'(op_b[idx]);
            took = in_valid && in_ready;
            tick();
            if (took) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_accepts"}, 64'(idx), 64'(LEN));
        chk({tag, "_in_ready_full"}, 64'(in_ready), 64'd0);

        if (check_lat) begin
            chk({tag, "_lat_k"}, 64'(out_valid), 64'd0);
            tick();
            chk({tag, "_lat_k1"}, 64'(out_valid), 64'd0);
            tick();
            chk({tag, "_lat_k2"}, 64'(out_valid), 64'd1);
        end else begin
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        end
        chk({tag, "_acc_out"}, 64'(acc_out), 64'(exp_acc));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));

        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = (i == 0);
            tick();
            start = 1'b0;
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_acc"}, 64'(acc_out), 64'(exp_acc));
            chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_released"}, 64'(out_valid), 64'd0);
        $display("[TB] %s: acc_out=%0d ovf=%0d expected acc=%0d ovf=%0d",
                 tag, acc_out, ovf, exp_acc, exp_ovf);
    endtask

    task automatic run_sat(input string tag, input int a0, input int b0,
                           input int a1, input int b1);
        longint s = longint'(a0 * b0 + a1 * b1);
        longint exp_acc;
        logic   exp_ovf;
        int     idx = 0;
        int     cyc = 0;
        bit     took;
        exp_ovf = (s >= (64'd1 << SAW));
        exp_acc = exp_ovf ? ((64'd1 << SAW) - 1) : s;

        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        while (idx < SLEN && cyc < 50) begin
            s_in_valid = 1'b1;
            s_a = N'(idx == 0 ? a0 : a1);
            s_b = N'(idx == 0 ? b0 : b1);
            took = s_in_ready;
            tick();
            if (took) idx++;
            cyc++;
        end
        s_in_valid = 1'b0;
        cyc = 0;
        while (!s_out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_out_valid"}, 64'(s_out_valid), 64'd1);
        chk({tag, "_acc_out"}, 64'(s_acc_out), 64'(exp_acc));
        chk({tag, "_ovf"}, 64'(s_ovf), 64'(exp_ovf));
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        $display("[TB] %s: acc_out=%0d ovf=%0d expected acc=%0d ovf=%0d",
                 tag, s_acc_out, s_ovf, exp_acc, exp_ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        // Reset state
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_acc_out", 64'(acc_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_s_out_valid", 64'(s_out_valid), 64'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // 1: back-to-back 3*5, latency check
        for (int i = 0; i < LEN; i++) begin op_a[i] = 3; op_b[i] = 5; end
        run_main("t1_basic", 0, 8'h00, 0, 1'b1);

        // 2: bubbles 1,0,1,0,1,1 with 15*15
        for (int i = 0; i < LEN; i++) begin op_a[i] = 15; op_b[i] = 15; end
        run_main("t2_bubbles", 2, 8'b0011_0101, 0, 1'b0);

        // 3: saturation on the narrow instance, then a clean block
        run_sat("t3_sat", 15, 15, 15, 15);
        run_sat("t3_after", 1, 1, 1, 1);

        // 4: backpressure with random operands
        for (int i = 0; i < LEN; i++) begin
            op_a[i] = int'($urandom_range(0, 15));
            op_b[i] = int'($urandom_range(0, 15));
        end
        run_main("t4_backpressure", 0, 8'h00, 5, 1'b0);

        // 5: abort after 2 accepts with start in the same cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        feed("t5", 2, 7, 9);
        in_valid = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        chk("t5_abort_in_ready", 64'(in_ready), 64'd0);
        chk("t5_abort_acc", 64'(acc_out), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("t5_no_out_valid", 64'(seen), 64'd0);
        for (int i = 0; i < LEN; i++) begin op_a[i] = 2; op_b[i] = 3; end
        run_main("t5_restart", 0, 8'h00, 0, 1'b0);

        // 6: asynchronous reset between edges mid-RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        feed("t6", 3, 15, 15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_in_ready", 64'(in_ready), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_acc_out", 64'(acc_out), 64'd0);
        chk("t6_ovf", 64'(ovf), 64'd0);
        #3;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < LEN; i++) begin
            op_a[i] = int'($urandom_range(0, 15));
            op_b[i] = int'($urandom_range(0, 15));
        end
        run_main("t6_restart", 0, 8'h00, 0, 1'b0);

        // Randomized blocks against the arithmetic model
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < LEN; i++) begin
                op_a[i] = int'($urandom_range(0, 15));
                op_b[i] = int'($urandom_range(0, 15));
            end
            run_main("rand_main", 1, 8'h00, int'($urandom_range(0, 3)), 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            run_sat("rand_sat", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
